// File: rtl/bus_port_fifo.sv
// Per-terminal bus port: TX queue toward the arbiter, ID/broadcast-filtered RX
// queue toward the device, plus saturating overflow/underflow/drop counters.

module bus_port_fifo_q #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_req,
  input  logic [W-1:0] wr_data,
  input  logic         rd_req,
  output logic [W-1:0] rd_data,
  output logic         not_empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          rd_ok, wr_ok;

  assign not_empty = (cnt != '0);
  assign full      = (cnt == CNT_MAX);
  assign rd_ok     = rd_req && not_empty;
  // A pop in the same cycle frees the slot, so a full queue can still take a write.
  assign wr_ok     = wr_req && (!full || rd_ok);
  assign rd_data   = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module bus_port_fifo #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [pckg_sz-1:0] wr_data,
  output logic               full,
  output logic               pndng,
  input  logic               pop,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               rd_en,
  output logic [pckg_sz-1:0] rd_data,
  output logic               rx_valid,
  output logic [7:0]         tx_ovf_cnt,
  output logic [7:0]         tx_unf_cnt,
  output logic [7:0]         rx_drop_cnt
);
  logic rx_full, rx_store, tx_ovf, tx_unf, rx_drop;

  assign rx_store = push && ((D_push[pckg_sz-1 -: 8] == id) ||
                             (D_push[pckg_sz-1 -: 8] == broadcast));

  bus_port_fifo_q #(.W(pckg_sz), .DEPTH(depth)) u_tx (
    .clk(clk), .rst_n(reset),
    .wr_req(wr_en), .wr_data(wr_data), .rd_req(pop),
    .rd_data(D_pop), .not_empty(pndng), .full(full)
  );

  bus_port_fifo_q #(.W(pckg_sz), .DEPTH(depth)) u_rx (
    .clk(clk), .rst_n(reset),
    .wr_req(rx_store), .wr_data(D_push), .rd_req(rd_en),
    .rd_data(rd_data), .not_empty(rx_valid), .full(rx_full)
  );

  assign tx_ovf  = wr_en && full && !(pop && pndng);
  assign tx_unf  = pop && !pndng;
  assign rx_drop = rx_store && rx_full && !(rd_en && rx_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf_cnt  <= '0;
      tx_unf_cnt  <= '0;
      rx_drop_cnt <= '0;
    end else begin
      if (tx_ovf  && tx_ovf_cnt  != 8'hFF) tx_ovf_cnt  <= tx_ovf_cnt  + 8'd1;
      if (tx_unf  && tx_unf_cnt  != 8'hFF) tx_unf_cnt  <= tx_unf_cnt  + 8'd1;
      if (rx_drop && rx_drop_cnt != 8'hFF) rx_drop_cnt <= rx_drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed bench for bus_port_fifo (id = 2, depth = 8): TX order/full/underflow,
// RX filtering/drop, pointer wrap and asynchronous reset.

module tb_bus_port_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, pop, push, rd_en;
  logic [15:0] wr_data, D_push, D_pop, rd_data;
  logic        full, pndng, rx_valid;
  logic [7:0]  tx_ovf_cnt, tx_unf_cnt, rx_drop_cnt;
  int          nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  bus_port_fifo #(.pckg_sz(16), .depth(8), .id(8'h02), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .pndng(pndng), .pop(pop), .D_pop(D_pop), .push(push), .D_push(D_push),
    .rd_en(rd_en), .rd_data(rd_data), .rx_valid(rx_valid),
    .tx_ovf_cnt(tx_ovf_cnt), .tx_unf_cnt(tx_unf_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en = 0; pop = 0; push = 0; rd_en = 0;
  endtask

  initial begin
    reset = 0; wr_data = '0; D_push = '0;
    idle();
    #12;
    chk("rst_pndng", pndng, 0);
    chk("rst_full", full, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_dpop", D_pop, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_cnts", {tx_ovf_cnt, tx_unf_cnt, rx_drop_cnt}, 0);
    reset = 1;

    // Basic FWFT order
    wr_en = 1; wr_data = 16'h0201; step();
    chk("t1_pndng", pndng, 1);
    chk("t1_head", D_pop, 16'h0201);
    wr_data = 16'h0302; step();
    wr_data = 16'h0403; step();
    chk("t1_head3", D_pop, 16'h0201);
    wr_en = 0; pop = 1; step();
    chk("t1_pop1", D_pop, 16'h0302);
    step();
    chk("t1_pop2", D_pop, 16'h0403);
    step();
    chk("t1_pop3", D_pop, 16'h0000);
    chk("t1_empty", pndng, 0);
    idle();

    // Fill, overflow, write+pop while full
    wr_en = 1;
    for (int k = 1; k <= 9; k++) begin
      wr_data = 16'h1000 + 16'(k); step();
      if (k == 7) chk("t2_notfull7", full, 0);
      if (k == 8) chk("t2_full8", full, 1);
    end
    chk("t2_ovf", tx_ovf_cnt, 1);
    pop = 1; wr_data = 16'h10AA; step();
    idle();
    chk("t2_full_keep", full, 1);
    chk("t2_ovf_keep", tx_ovf_cnt, 1);
    chk("t2_head", D_pop, 16'h1002);
    pop = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_order", D_pop, (i == 7) ? 16'h10AA : 16'h1002 + 16'(i));
      step();
    end
    idle();
    chk("t2_drained", pndng, 0);
    chk("t2_unf0", tx_unf_cnt, 0);

    // Underflow saturation, write+pop on empty
    pop = 1;
    for (int i = 0; i < 254; i++) step();
    chk("t3_unf254", tx_unf_cnt, 254);
    for (int i = 0; i < 46; i++) step();
    chk("t3_unf_sat", tx_unf_cnt, 255);
    wr_en = 1; wr_data = 16'h0777; step();
    idle();
    chk("t3_keep_pndng", pndng, 1);
    chk("t3_keep_data", D_pop, 16'h0777);
    pop = 1; step(); idle();
    chk("t3_drain", pndng, 0);

    // RX filtering
    push = 1;
    D_push = 16'h0211; step();
    chk("t4_rxv", rx_valid, 1);
    D_push = 16'h0522; step();
    D_push = 16'hFF33; step();
    idle();
    chk("t4_rd0", rd_data, 16'h0211);
    rd_en = 1; step();
    chk("t4_rd1", rd_data, 16'hFF33);
    step();
    chk("t4_rd2", rd_data, 16'h0000);
    chk("t4_rxv0", rx_valid, 0);
    chk("t4_drop0", rx_drop_cnt, 0);
    idle();

    // RX full, drop, non-matching while full, push+read while full
    push = 1;
    for (int k = 1; k <= 8; k++) begin
      D_push = 16'h0200 + 16'(k); step();
    end
    D_push = 16'h02EE; step();
    chk("t5_drop1", rx_drop_cnt, 1);
    D_push = 16'h0533; step();
    chk("t5_nomatch_nocount", rx_drop_cnt, 1);
    D_push = 16'hFF44; rd_en = 1; step();
    idle();
    chk("t5_drop_keep", rx_drop_cnt, 1);
    chk("t5_head", rd_data, 16'h0202);
    rd_en = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t5_order", rd_data, (i == 7) ? 16'hFF44 : 16'h0202 + 16'(i));
      step();
    end
    idle();
    chk("t5_empty", rx_valid, 0);

    // Pointer wrap with 3 resident entries
    wr_en = 1;
    for (int k = 0; k < 3; k++) begin
      wr_data = 16'h3000 + 16'(k); step();
    end
    pop = 1;
    for (int i = 0; i < 20; i++) begin
      wr_data = 16'h3003 + 16'(i); step();
      chk("t6_wrap", D_pop, 16'h3001 + 16'(i));
    end
    idle();
    chk("t6_pre_rst", {tx_ovf_cnt, tx_unf_cnt, rx_drop_cnt}, 24'h01FF01);

    // Asynchronous reset between edges
    #1;
    reset = 0;
    #1;
    chk("t6_rst_pndng", pndng, 0);
    chk("t6_rst_dpop", D_pop, 0);
    chk("t6_rst_cnts", {tx_ovf_cnt, tx_unf_cnt, rx_drop_cnt}, 0);
    step();
    reset = 1;
    step();
    chk("t6_post_rst", pndng, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/bus_port_fifo.md
# bus_port_fifo

Per-terminal port buffer between a device-side agent and the bus generator/arbiter. The TX side queues packets from the device and presents them to the arbiter via `pndng`/`pop`/`D_pop`. The RX side captures `push`/`D_push` deliveries addressed to this terminal's ID or to broadcast, and queues them for the device. One instance per bus terminal; the arbiter's per-driver signal slices connect directly to it.

## Interface

- `pckg_sz`, 16: packet width in bits; bits [pckg_sz-1 -: 8] hold the destination ID.
- `depth`, 8: entries per FIFO (TX and RX each); power of two, ≥2.
- `id`, 0: this terminal's 8-bit ID.
- `broadcast`, 8'hFF: destination ID accepted by every terminal.

- `clk`  in  1  bus clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  device writes `wr_data` into TX FIFO.
- `wr_data`  in  pckg_sz  packet to transmit.
- `full`  out  1  TX FIFO holds `depth` entries.
- `pndng`  out  1  TX FIFO non-empty (to arbiter).
- `pop`  in  1  arbiter consumes TX head.
- `D_pop`  out  pckg_sz  TX head, first-word-fall-through.
- `push`  in  1  arbiter delivers `D_push`.
- `D_push`  in  pckg_sz  delivered packet.
- `rd_en`  in  1  device consumes RX head.
- `rd_data`  out  pckg_sz  RX head, first-word-fall-through.
- `rx_valid`  out  1  RX FIFO non-empty.
- `tx_ovf_cnt`  out  8  TX writes dropped because the FIFO was full; saturates at 255.
- `tx_unf_cnt`  out  8  pops received while empty; saturates at 255.
- `rx_drop_cnt`  out  8  matching pushes dropped because the RX FIFO was full; saturates at 255.

## Operation

- Each FIFO: circular buffer, read/write pointers of log2(depth) bits, occupancy counter of log2(depth)+1 bits. Pointers wrap from depth-1 to 0.
- TX write is accepted iff `wr_en` && (!full || pop-accepted-same-cycle). A refused write is discarded and increments `tx_ovf_cnt`.
- TX pop is accepted iff `pop` && `pndng`. A pop while empty is ignored and increments `tx_unf_cnt`. A write to an empty FIFO in the same cycle as a pop is accepted; the pop is not.
- TX full, `wr_en` and `pop` all in one cycle: both operations happen and occupancy stays at depth.
- RX match: `D_push[pckg_sz-1 -: 8]` == `id` or == `broadcast`. A non-matching push is ignored silently and not counted.
- RX store is accepted iff `push` && match && (rx not full || `rd_en` accepted same cycle). A refused matching push increments `rx_drop_cnt`.
- RX read is accepted iff `rd_en` && `rx_valid`. `rd_en` while empty is a no-op.
- `D_pop`/`rd_data` equal the memory at the read pointer when non-empty, else 0.
- Counters saturate at 8'hFF and never wrap; they clear only on reset.
- Reset (asynchronous, any time, including mid-transfer): pointers, occupancy and counters go to 0. `pndng`, `full`, `rx_valid` = 0; `D_pop`, `rd_data` = 0. All queued data is discarded. Memory contents are not reset.

## Timing

- Write at edge N: `pndng` rises after edge N, and `D_pop` shows the packet in cycle N+1. One-cycle latency.
- Pop at edge N: the head advances, and `D_pop` shows the next entry (or 0) after edge N. `pndng` falls after edge N if it was the last entry.
- `full` and `pndng` are decoded from registered occupancy; no combinational path from `pop` to `pndng`.
- RX side: same timing, with `push` in place of write and `rd_en` in place of pop.
- Minimum TX transit is 1 cycle: packet written at edge N can be popped at edge N+1.
- Sustained throughput is one write plus one pop per cycle per FIFO.
- Reset release: the first edge with `reset` high may accept operations.

## Test plan

- Reset, then write 0x0201, 0x0302, 0x0403 on consecutive cycles with no pop: `pndng` = 1 from cycle 1, `D_pop` = 0x0201. Pop three times: `D_pop` shows 0x0302, then 0x0403, then 0. `pndng` = 0 after the third pop.
- Write 9 packets with depth=8 and no pops: `full` = 1 after the 8th write, and `tx_ovf_cnt` = 1. Then write and pop in the same cycle while full: occupancy stays 8, `tx_ovf_cnt` unchanged, FIFO order preserved.
- Pop while empty 300 times: `tx_unf_cnt` saturates at 255. Pop on an empty FIFO in the same cycle as a write: packet retained, `pndng` = 1 next cycle.
- With `id` = 2, push 0x0211, 0x0522 and 0xFF33: `rx_valid` = 1, and `rd_data` reads 0x0211 then 0xFF33. 0x0522 never appears; `rx_drop_cnt` = 0.
- Fill the RX FIFO with 8 matching pushes, then push a 9th without `rd_en`: `rx_drop_cnt` = 1. Push plus `rd_en` in the same cycle: both accepted.
- Wrap-around: 20 write/pop pairs interleaved with 3 entries resident: data order is correct across the pointer wrap. Assert `reset` low mid-stream: `pndng`, `D_pop` and counters go to 0 immediately, without waiting for a clock edge.
